instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 162 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetches one instruction word at a time from instruction memory, holds it
//   for the datapath until it is consumed, then computes the next PC from the
//   redirect controls (register jump, PC-relative jump, taken branch or
//   sequential). Accepting a TRAP opcode parks the unit in HALT until reset.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   imem_req / imem_addr  : read request and byte address (= PC) to memory
//   imem_ack / imem_rdata : read data valid / instruction word (bit 0 = MSB)
//   instruction           : registered word presented to control logic
//   instr_valid           : instruction holds a live word
//   instr_ready           : datapath consumes the word this cycle
//   BRANCH, BR_TAKEN,
//   JUMP, JUMP_REG        : redirect controls, sampled only on acceptance
//   reg_target            : register jump target (JR/JALR)
//   link_pc               : PC+4 of the held instruction (JAL write-back)
//   instr_count           : number of accepted instructions (wraps at 2^32)
//   halted                : a TRAP has been accepted
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [0:31] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [0:31] imem_addr,
  input  logic        imem_ack,
  input  logic [0:31] imem_rdata,
  output logic [0:31] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        BRANCH,
  input  logic        BR_TAKEN,
  input  logic        JUMP,
  input  logic        JUMP_REG,
  input  logic [0:31] reg_target,
  output logic [0:31] link_pc,
  output logic [0:31] instr_count,
  output logic        halted
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [0:5] OPC_TRAP = 6'h11;

  state_t      state_q, state_d;
  logic [0:31] pc_q, pc_d;
  logic [0:31] link_q, link_d;
  logic [0:31] instr_q, instr_d;
  logic [0:31] count_q, count_d;
  logic        halted_q, halted_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;
  logic [0:31] next_pc_s;

  // Sign-extend the 26-bit jump displacement (bit 0 is its sign).
  function automatic logic [0:31] sext26(input logic [0:25] imm);
    return {{6{imm[0]}}, imm};
  endfunction

  // Sign-extend the 16-bit branch displacement (bit 0 is its sign).
  function automatic logic [0:31] sext16(input logic [0:15] imm);
    return {{16{imm[0]}}, imm};
  endfunction

  // Redirect target for the held instruction, highest priority first.
  // link_q already equals pc+4, so relative targets build on it.
  always_comb begin
    next_pc_s = link_q;
    if (JUMP_REG) begin
      next_pc_s = reg_target;
    end else if (JUMP) begin
      next_pc_s = link_q + sext26(instr_q[6:31]);
    end else if (BRANCH && BR_TAKEN) begin
      next_pc_s = link_q + sext16(instr_q[16:31]);
    end else begin
      next_pc_s = link_q;
    end
  end

  // Next-state and next-register computation for the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    count_d = count_q;
    case (state_q)
      FETCH: begin
        // req_q gates the ack so a straggling ack in the cycle right after
        // reset (request not yet issued) is not mistaken for data.
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          state_d = HOLD;
        end else begin
          state_d = FETCH;
        end
      end
      HOLD: begin
        if (instr_ready) begin
          pc_d    = next_pc_s;
          count_d = count_q + 32'd1;
          if (instr_q[0:5] == OPC_TRAP) begin
            state_d = HALT;
          end else begin
            state_d = FETCH;
          end
        end else begin
          state_d = HOLD;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
    // Outputs are registered, so they are derived from the next state.
    req_d    = (state_d == FETCH);
    valid_d  = (state_d == HOLD);
    halted_d = (state_d == HALT);
    link_d   = pc_d + 32'd4;
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      link_q   <= RESET_PC + 32'd4;
      instr_q  <= 32'h00000000;
      count_q  <= 32'h00000000;
      halted_q <= 1'b0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      link_q   <= link_d;
      instr_q  <= instr_d;
      count_q  <= count_d;
      halted_q <= halted_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign link_pc     = link_q;
  assign instr_count = count_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//   Directed bench for instr_fetch_unit: sequential fetch, branches, JAL,
//   redirect priority, stall, trap/halt, and reset behaviour.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_ack;
  logic [0:31] imem_rdata;
  logic [0:31] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic        BRANCH;
  logic        BR_TAKEN;
  logic        JUMP;
  logic        JUMP_REG;
  logic [0:31] reg_target;
  logic [0:31] link_pc;
  logic [0:31] instr_count;
  logic        halted;

  int n_vec;
  int n_err;
  logic [31:0] exp_count;

  instr_fetch_unit #(.RESET_PC(32'h00000000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instruction(instruction),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .BRANCH     (BRANCH),
    .BR_TAKEN   (BR_TAKEN),
    .JUMP       (JUMP),
    .JUMP_REG   (JUMP_REG),
    .reg_target (reg_target),
    .link_pc    (link_pc),
    .instr_count(instr_count),
    .halted     (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one word with ack while a request is outstanding; ends in HOLD.
  task automatic fetch_word(input logic [31:0] w);
    imem_ack   = 1'b1;
    imem_rdata = w;
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = 32'h00000000;
  endtask

  // Accept the held word with the given redirect controls.
  task automatic accept(input logic br, input logic tk, input logic j,
                        input logic jr, input logic [31:0] tgt);
    BRANCH      = br;
    BR_TAKEN    = tk;
    JUMP        = j;
    JUMP_REG    = jr;
    reg_target  = tgt;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    BRANCH      = 1'b0;
    BR_TAKEN    = 1'b0;
    JUMP        = 1'b0;
    JUMP_REG    = 1'b0;
    reg_target  = 32'h00000000;
    exp_count   = exp_count + 32'd1;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    exp_count   = 32'd0;
    reset       = 1'b1;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h00000000;
    instr_ready = 1'b0;
    BRANCH      = 1'b0;
    BR_TAKEN    = 1'b0;
    JUMP        = 1'b0;
    JUMP_REG    = 1'b0;
    reg_target  = 32'h00000000;

    // Reset state
    #2;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_halt",  32'(halted), 32'd0);
    chk("rst_addr",  imem_addr, 32'h00000000);
    chk("rst_instr", instruction, 32'h00000000);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_link",  link_pc, 32'h00000004);

    // Sequential fetch
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("seq_req1",  32'(imem_req), 32'd1);
    chk("seq_addr0", imem_addr, 32'h00000000);
    fetch_word(32'h00221820);
    chk("seq_instr", instruction, 32'h00221820);
    chk("seq_valid", 32'(instr_valid), 32'd1);
    chk("seq_req0",  32'(imem_req), 32'd0);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("seq_addr4", imem_addr, 32'h00000004);
    chk("seq_count", instr_count, 32'd1);
    chk("seq_valid0", 32'(instr_valid), 32'd0);
    chk("seq_link",  link_pc, 32'h00000008);

    // Register jump to 0x10, then taken branch with zero offset
    fetch_word(32'h00000000);
    accept(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000010);
    chk("jr_addr10", imem_addr, 32'h00000010);
    fetch_word(32'h10800000);
    accept(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("br0_addr", imem_addr, 32'h00000014);

    // JAL at 0x20
    fetch_word(32'h00000000);
    accept(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000020);
    chk("jr_addr20", imem_addr, 32'h00000020);
    fetch_word(32'h0c00000c);
    chk("jal_link", link_pc, 32'h00000024);
    accept(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("jal_addr", imem_addr, 32'h00000030);

    // Backward taken branch at 0x40
    fetch_word(32'h00000000);
    accept(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000040);
    fetch_word(32'h1000FFF8);
    accept(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("brneg_addr", imem_addr, 32'h0000003C);

    // Same branch, not taken
    fetch_word(32'h00000000);
    accept(1'b0, 1'b0, 1'b0, 1'b1, 32'h00000040);
    fetch_word(32'h1000FFF8);
    accept(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("brnt_addr", imem_addr, 32'h00000044);

    // Redirect priority: JUMP_REG beats taken branch
    fetch_word(32'h1000FFF8);
    accept(1'b1, 1'b1, 1'b0, 1'b1, 32'h00000100);
    chk("prio_addr", imem_addr, 32'h00000100);
    chk("prio_count", instr_count, exp_count);

    // Stall 3 cycles in HOLD, with a stray ack that must be ignored
    fetch_word(32'h12345678);
    imem_ack   = 1'b1;
    imem_rdata = 32'hA5A5A5A5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_instr", instruction, 32'h12345678);
      chk("stall_count", instr_count, exp_count);
      chk("stall_addr",  imem_addr, 32'h00000100);
      chk("stall_req",   32'(imem_req), 32'd0);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    imem_ack   = 1'b0;
    imem_rdata = 32'h00000000;
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("stall_next", imem_addr, 32'h00000104);
    chk("stall_cnt2", instr_count, 32'd11);

    // TRAP
    fetch_word(32'h44000000);
    accept(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("trap_halt",  32'(halted), 32'd1);
    chk("trap_count", instr_count, 32'd12);
    imem_ack    = 1'b1;
    imem_rdata  = 32'h00221820;
    instr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("halt_req",   32'(imem_req), 32'd0);
      chk("halt_valid", 32'(instr_valid), 32'd0);
      chk("halt_flag",  32'(halted), 32'd1);
      chk("halt_count", instr_count, 32'd12);
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b0;

    // Reset out of HALT
    reset = 1'b1;
    #1;
    chk("hrst_addr",  imem_addr, 32'h00000000);
    chk("hrst_halt",  32'(halted), 32'd0);
    chk("hrst_count", instr_count, 32'd0);
    chk("hrst_req",   32'(imem_req), 32'd0);
    exp_count = 32'd0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("hrst_req1", 32'(imem_req), 32'd1);

    // Reset mid-hold, then a late ack across reset release
    fetch_word(32'hCAFEF00D);
    chk("mh_valid", 32'(instr_valid), 32'd1);
    reset      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEADBEEF;
    #1;
    chk("mh_instr", instruction, 32'h00000000);
    chk("mh_valid0", 32'(instr_valid), 32'd0);
    chk("mh_req0",  32'(imem_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("late_req",   32'(imem_req), 32'd1);
    chk("late_valid", 32'(instr_valid), 32'd0);
    chk("late_instr", instruction, 32'h00000000);
    @(negedge clk);
    chk("new_instr", instruction, 32'hDEADBEEF);
    chk("new_valid", 32'(instr_valid), 32'd1);
    imem_ack = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
